// File: rtl/spi_seq_if.sv
// spi_seq_if: command/stream handshake and SPI core register-port bundle for spi_xfer_sequencer
interface spi_seq_if #(
  parameter int CNT_W = 8,
  parameter int SS_W = 16
);
  logic cmd_valid, cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic [SS_W-1:0] cmd_ss;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic rx_valid, busy, done, err;
  logic spi_select, read_n, write_n;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic readyfordata, dataavailable;
  modport master (
    input cmd_valid, cmd_len, cmd_ss, tx_data, tx_valid, data_to_cpu, readyfordata, dataavailable,
    output cmd_ready, tx_ready, rx_data, rx_valid, busy, done, err,
    output spi_select, mem_addr, read_n, write_n, data_from_cpu
  );
  modport slave (
    output cmd_valid, cmd_len, cmd_ss, tx_data, tx_valid, data_to_cpu, readyfordata, dataavailable,
    input cmd_ready, tx_ready, rx_data, rx_valid, busy, done, err,
    input spi_select, mem_addr, read_n, write_n, data_from_cpu
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: runs multi-byte SPI transactions through the 8-bit SPI core register port.
// Defining SPI_SEQ_TIMEOUT_EN adds a watchdog on the wait states that aborts with err.
module spi_xfer_sequencer #(
  parameter int CNT_W = 8,
  parameter int SS_W = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic reset_n,
  spi_seq_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WR_STAT, WR_SS, WR_CTL1, GET_TX, WAIT_TRDY, WR_TX, WAIT_RRDY, RD_RX, WR_CTL0, DONE
  } state_t;
  state_t state, state_nx;
  logic [1:0] ph;
  logic [CNT_W-1:0] cnt;
  logic [SS_W-1:0] ss;
  logic [7:0] tx_byte, rx_byte;
  logic rx_pulse, err_q, acc, last, cap, tmo, unused;
  logic [2:0] addr;
  logic [15:0] wdata;
  // each access is ph 0..1 with select high, ph 2 is the mandatory idle cycle
  assign acc = state inside {WR_STAT, WR_SS, WR_CTL1, WR_TX, RD_RX, WR_CTL0};
  assign last = ph == 2'd2;
  assign cap = state == RD_RX && ph == 2'd1;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wd <= '0;
    else wd <= state_nx != state ? '0 : wd + 1'b1;
  assign tmo = (state == WAIT_TRDY || state == WAIT_RRDY) && wd == WD_MAX;
  assign unused = ^bus.data_to_cpu[15:8];
`else
  assign tmo = 1'b0;
  assign unused = ^{bus.data_to_cpu[15:8], TIMEOUT_CYC[0]};
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !bus.cmd_valid ? IDLE : bus.cmd_len == '0 ? DONE : WR_STAT;
      WR_STAT: state_nx = last ? WR_SS : WR_STAT;
      WR_SS: state_nx = last ? WR_CTL1 : WR_SS;
      WR_CTL1: state_nx = last ? GET_TX : WR_CTL1;
      GET_TX: state_nx = bus.tx_valid ? WAIT_TRDY : GET_TX;
      WAIT_TRDY: state_nx = bus.readyfordata ? WR_TX : tmo ? WR_CTL0 : WAIT_TRDY;
      WR_TX: state_nx = last ? WAIT_RRDY : WR_TX;
      WAIT_RRDY: state_nx = bus.dataavailable ? RD_RX : tmo ? WR_CTL0 : WAIT_RRDY;
      RD_RX: state_nx = !last ? RD_RX : cnt == '0 ? WR_CTL0 : GET_TX;
      WR_CTL0: state_nx = last ? DONE : WR_CTL0;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ph <= 2'd0;
      cnt <= '0;
      ss <= '0;
      tx_byte <= 8'h00;
      rx_byte <= 8'h00;
      rx_pulse <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      ph <= state_nx != state ? 2'd0 : acc ? ph + 2'd1 : 2'd0;
      rx_pulse <= cap;
      if (state == IDLE && bus.cmd_valid) begin
        cnt <= bus.cmd_len;
        ss <= bus.cmd_ss;
        err_q <= 1'b0;
      end
      if (state == GET_TX && bus.tx_valid) tx_byte <= bus.tx_data;
      if (cap) begin
        rx_byte <= bus.data_to_cpu[7:0];
        cnt <= cnt - 1'b1;
      end
      if ((state == WAIT_TRDY || state == WAIT_RRDY) && state_nx == WR_CTL0) err_q <= 1'b1;
    end
  assign addr = state == WR_STAT ? 3'd2 : state == WR_SS ? 3'd5 :
                (state == WR_CTL1 || state == WR_CTL0) ? 3'd3 : state == WR_TX ? 3'd1 : 3'd0;
  assign wdata = state == WR_SS ? 16'(ss) : state == WR_CTL1 ? 16'h0400 :
                 state == WR_TX ? {8'h00, tx_byte} : 16'h0000;
  assign bus.spi_select = acc && !last;
  assign bus.mem_addr = bus.spi_select ? addr : 3'd0;
  assign bus.data_from_cpu = bus.spi_select ? wdata : 16'h0000;
  assign bus.read_n = !(bus.spi_select && state == RD_RX);
  assign bus.write_n = !(bus.spi_select && state != RD_RX);
  assign bus.cmd_ready = reset_n && state == IDLE;
  assign bus.tx_ready = state == GET_TX;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.err = err_q;
  assign bus.rx_data = rx_byte;
  assign bus.rx_valid = rx_pulse;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: directed bench with a loopback SPI core model and a transaction-level
// scoreboard of expected register accesses and RX bytes.
module tb_spi_xfer_sequencer;
  logic clk, reset_n, hold_rrdy;
  spi_seq_if #(.CNT_W(8), .SS_W(16)) bus ();
  spi_xfer_sequencer #(.CNT_W(8), .SS_W(16), .TIMEOUT_CYC(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {bit rd; logic [2:0] addr; logic [15:0] data;} acc_t;
  typedef struct {logic [7:0] b; int gap;} tx_t;
  acc_t exp_acc[$];
  logic [7:0] exp_rx[$];
  tx_t tx_q[$];
  int tests = 0, fails = 0;
  int run = 0, gap = 100, last_gap = 0, acc_cnt = 0, sel_cyc = 0, rx_cnt = 0, done_cnt = 0, tx_wr_cnt = 0;
  int trdy_dly = 3;
  logic [7:0] last_rx = 8'h00;
  bit p_done = 0, p_rd_done = 0;
  logic [2:0] p_addr;
  logic [15:0] p_data;
  logic [1:0] p_str;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // loopback core: a txdata write returns the same byte on rxdata ten cycles later
  logic trdy, rrdy, toe, roe, sso;
  logic [7:0] rx_reg, shift;
  int sel_cnt, trdy_cd, rx_cd;
  assign bus.readyfordata = trdy;
  assign bus.dataavailable = rrdy;
  assign bus.data_to_cpu = bus.mem_addr == 3'd0 ? {8'h00, rx_reg} :
                           bus.mem_addr == 3'd2 ? {8'h00, rrdy, trdy, 1'b0, toe, roe, 3'b000} : 16'h0000;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sel_cnt <= 0; trdy <= 1; rrdy <= 0; rx_reg <= 0; shift <= 0;
      toe <= 0; roe <= 0; sso <= 0; trdy_cd <= 0; rx_cd <= 0;
    end else begin
      sel_cnt <= bus.spi_select ? sel_cnt + 1 : 0;
      if (trdy_cd == 1) trdy <= 1;
      if (trdy_cd != 0) trdy_cd <= trdy_cd - 1;
      if (rx_cd == 1 && !hold_rrdy) begin
        if (rrdy) roe <= 1;
        rrdy <= 1;
        rx_reg <= shift;
      end
      if (rx_cd != 0) rx_cd <= rx_cd - 1;
      if (bus.spi_select && sel_cnt == 1) begin
        if (!bus.write_n && bus.mem_addr == 3'd1) begin
          chk("sso_held_at_tx", {31'd0, sso}, 1);
          if (!trdy) toe <= 1;
          trdy <= 0; trdy_cd <= trdy_dly; rx_cd <= 10;
          shift <= bus.data_from_cpu[7:0];
          tx_wr_cnt <= tx_wr_cnt + 1;
        end
        if (!bus.write_n && bus.mem_addr == 3'd2) begin toe <= 0; roe <= 0; end
        if (!bus.write_n && bus.mem_addr == 3'd3) sso <= bus.data_from_cpu[10];
        if (!bus.read_n && bus.mem_addr == 3'd0) rrdy <= 0;
      end
    end

  // stream client: presents queued bytes, optionally holding off before one of them
  initial begin
    bit take;
    tx_t t;
    bus.tx_valid = 0;
    bus.tx_data = 0;
    forever begin
      @(negedge clk);
      take = bus.tx_valid && bus.tx_ready;
      @(posedge clk);
      #1;
      if (take && tx_q.size() > 0) t = tx_q.pop_front();
      if (tx_q.size() > 0 && tx_q[0].gap > 0) begin
        t = tx_q[0]; t.gap--; tx_q[0] = t; bus.tx_valid = 0;
      end else if (tx_q.size() > 0) begin
        bus.tx_valid = 1; bus.tx_data = tx_q[0].b;
      end else bus.tx_valid = 0;
    end
  end

  // compare process: access framing, scoreboard order, rx bytes and done on every cycle
  always @(negedge clk) begin
    acc_t e;
    if (!reset_n) begin
      run = 0; gap = 100; p_done = 0; p_rd_done = 0;
    end else begin
      chk("cmd_ready_vs_busy", {31'd0, bus.cmd_ready}, {31'd0, !bus.busy});
      if (bus.tx_ready) chk("tx_ready_busy", {31'd0, bus.busy}, 1);
      if (bus.rx_valid) begin
        rx_cnt++;
        last_rx = bus.rx_data;
        chk("rx_after_read", {31'd0, p_rd_done}, 1);
        if (exp_rx.size() == 0) begin
          fails++; tests++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no byte", bus.rx_data);
        end else chk("rx_data", bus.rx_data, exp_rx.pop_front());
      end
      p_rd_done = 0;
      if (bus.spi_select) begin
        sel_cyc++;
        if (run == 0) last_gap = gap;
        if (run == 1) begin
          chk("addr_stable", bus.mem_addr, p_addr);
          chk("wdata_stable", bus.data_from_cpu, p_data);
          chk("strobe_stable", {bus.read_n, bus.write_n}, p_str);
          chk("one_strobe", {31'd0, bus.read_n ^ bus.write_n}, 1);
          acc_cnt++;
          if (exp_acc.size() == 0) begin
            fails++; tests++;
            $display("FAIL acc_unexpected: got addr %0d rd %0d, expected no access", bus.mem_addr, !bus.read_n);
          end else begin
            e = exp_acc.pop_front();
            chk("acc_is_read", {31'd0, !bus.read_n}, {31'd0, e.rd});
            chk("acc_addr", bus.mem_addr, e.addr);
            if (!e.rd) chk("acc_wdata", bus.data_from_cpu, e.data);
          end
          p_rd_done = !bus.read_n;
        end
        if (run >= 2) chk("access_len", run + 1, 2);
        run++; gap = 0;
      end else begin
        if (run != 0) chk("access_len", run, 2);
        chk("idle_strobes", {bus.read_n, bus.write_n}, 2'b11);
        run = 0; gap++;
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_single", {31'd0, p_done}, 0);
        chk("done_acc_left", exp_acc.size(), 0);
        chk("done_rx_left", exp_rx.size(), 0);
      end
      p_done = bus.done;
      p_addr = bus.mem_addr; p_data = bus.data_from_cpu; p_str = {bus.read_n, bus.write_n};
    end
  end

  // model: the register-access sequence and RX bytes a command must produce
  task automatic plan(input int len, input logic [15:0] ss, input logic [31:0] bytes, input int gap2, input bit rx_ok);
    logic [7:0] b;
    if (len == 0) return;
    exp_acc.push_back('{0, 3'd2, 16'h0000});
    exp_acc.push_back('{0, 3'd5, ss});
    exp_acc.push_back('{0, 3'd3, 16'h0400});
    for (int i = 0; i < len; i++) begin
      b = bytes[8*i +: 8];
      tx_q.push_back('{b, i == 1 ? gap2 : 0});
      if (i == 0 || rx_ok) exp_acc.push_back('{0, 3'd1, {8'h00, b}});
      if (rx_ok) begin
        exp_acc.push_back('{1, 3'd0, 16'h0000});
        exp_rx.push_back(b);
      end
    end
    exp_acc.push_back('{0, 3'd3, 16'h0000});
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic [15:0] ss);
    int n = 0;
    while (!bus.cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_timeout", {31'd0, bus.cmd_ready}, 1);
    bus.cmd_len = len; bus.cmd_ss = ss; bus.cmd_valid = 1;
    @(posedge clk);
    #1 bus.cmd_valid = 0;
  endtask

  task automatic wait_done();
    int d = done_cnt, n = 0;
    while (done_cnt == d && n < 3000) begin @(posedge clk); n++; end
    chk("done_seen", {31'd0, done_cnt != d}, 1);
    @(negedge clk);
  endtask

  initial begin
    int a0, r0, s0, d0, t0, n;
    reset_n = 0; hold_rrdy = 0;
    bus.cmd_valid = 0; bus.cmd_len = 0; bus.cmd_ss = 0;
    #3;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    chk("rst_select", {31'd0, bus.spi_select}, 0);
    chk("rst_strobes", {bus.read_n, bus.write_n}, 2'b11);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_addr_data", {bus.mem_addr, bus.data_from_cpu}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 1);

    // zero-length command: done the next cycle, no core access
    s0 = sel_cyc; d0 = done_cnt;
    send_cmd(0, 16'h0001);
    @(negedge clk);
    chk("len0_done_next", {31'd0, bus.done}, 1);
    repeat (4) @(negedge clk);
    chk("len0_no_select", sel_cyc - s0, 0);
    chk("len0_done_count", done_cnt - d0, 1);

    // single byte
    a0 = acc_cnt; r0 = rx_cnt;
    plan(1, 16'h0001, 32'h000000A5, 0, 1);
    send_cmd(1, 16'h0001);
    wait_done();
    chk("b1_rx_data", last_rx, 8'hA5);
    chk("b1_rx_count", rx_cnt - r0, 1);
    chk("b1_accesses", acc_cnt - a0, 6);
    chk("b1_err", {31'd0, bus.err}, 0);

    // three bytes, client stall before byte 2, slow TRDY
    trdy_dly = 25;
    a0 = acc_cnt; r0 = rx_cnt;
    plan(3, 16'h0004, 32'h00030201, 30, 1);
    send_cmd(3, 16'h0004);
    wait_done();
    trdy_dly = 3;
    chk("b3_rx_count", rx_cnt - r0, 3);
    chk("b3_last_rx", last_rx, 8'h03);
    chk("b3_accesses", acc_cnt - a0, 10);
    chk("b3_toe_roe", {toe, roe}, 2'b00);

    // command while busy is ignored
    a0 = acc_cnt; r0 = rx_cnt;
    plan(2, 16'h0010, 32'h0000C35A, 0, 1);
    send_cmd(2, 16'h0010);
    bus.cmd_len = 7; bus.cmd_ss = 16'h8000; bus.cmd_valid = 1;
    repeat (15) begin @(negedge clk); chk("busy_cmd_ready_low", {31'd0, bus.cmd_ready}, 0); end
    @(posedge clk); #1 bus.cmd_valid = 0;
    wait_done();
    chk("busy_rx_count", rx_cnt - r0, 2);
    chk("busy_last_rx", last_rx, 8'hC3);
    chk("busy_accesses", acc_cnt - a0, 8);

    // reset while waiting for the RX byte
    plan(2, 16'h0002, 32'h00002211, 0, 1);
    t0 = tx_wr_cnt; n = 0;
    send_cmd(2, 16'h0002);
    while (tx_wr_cnt == t0 && n < 500) begin @(negedge clk); n++; end
    chk("rst_mid_tx_seen", {31'd0, tx_wr_cnt != t0}, 1);
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_select", {31'd0, bus.spi_select}, 0);
    chk("mid_rst_strobes", {bus.read_n, bus.write_n}, 2'b11);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    chk("mid_rst_addr_data", {bus.mem_addr, bus.data_from_cpu}, 0);
    exp_acc.delete(); exp_rx.delete(); tx_q.delete();
    @(negedge clk);
    reset_n = 1;
    a0 = acc_cnt; r0 = rx_cnt;
    plan(1, 16'h0100, 32'h0000003C, 0, 1);
    send_cmd(1, 16'h0100);
    wait_done();
    chk("post_rst_rx", last_rx, 8'h3C);
    chk("post_rst_rx_count", rx_cnt - r0, 1);
    chk("post_rst_accesses", acc_cnt - a0, 6);

`ifdef SPI_SEQ_TIMEOUT_EN
    // RX never arrives: watchdog aborts after 64 wait cycles
    hold_rrdy = 1;
    r0 = rx_cnt;
    plan(2, 16'h0001, 32'h00008877, 0, 0);
    send_cmd(2, 16'h0001);
    wait_done();
    chk("to_err", {31'd0, bus.err}, 1);
    chk("to_wait_gap", last_gap, 65);
    chk("to_tx_left", tx_q.size(), 1);
    chk("to_rx_count", rx_cnt - r0, 0);
    hold_rrdy = 0;
    tx_q.delete();
    send_cmd(0, 16'h0001);
    chk("to_err_cleared", {31'd0, bus.err}, 0);
    wait_done();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
